// File: rtl/sd_dma_master_wb.sv
// Wishbone master DMA between SD data-path FIFOs and memory.
// Optional bus-error handling enabled by defining SD_DMA_ERR_EN.
module sd_dma_master_wb #(
  parameter int ADDR_W    = 32,
  parameter int BLKSIZE_W = 12,
  parameter int BLKCNT_W  = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start_rx_i,
  input  logic                 start_tx_i,
  input  logic                 abort_i,
  input  logic [ADDR_W-1:0]    dma_addr_i,
  input  logic [BLKSIZE_W-1:0] block_size_i,
  input  logic [BLKCNT_W-1:0]  block_count_i,
  output logic [ADDR_W-1:0]    m_wb_adr_o,
  output logic [31:0]          m_wb_dat_o,
  input  logic [31:0]          m_wb_dat_i,
  output logic [3:0]           m_wb_sel_o,
  output logic                 m_wb_we_o,
  output logic                 m_wb_cyc_o,
  output logic                 m_wb_stb_o,
  input  logic                 m_wb_ack_i,
`ifdef SD_DMA_ERR_EN
  input  logic                 m_wb_err_i,
  output logic                 dma_err_o,
`endif
  input  logic [31:0]          rx_fifo_dat_i,
  input  logic                 rx_fifo_empty_i,
  output logic                 rx_fifo_rd_o,
  output logic [31:0]          tx_fifo_dat_o,
  input  logic                 tx_fifo_full_i,
  output logic                 tx_fifo_wr_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int REM_W = BLKSIZE_W - 2 + BLKCNT_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BUS,
    S_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [REM_W-1:0]  rem_q;
  logic              rx_q;
  logic [31:0]       wdat_q;
  logic [31:0]       tdat_q;
  logic              twr_q;

  logic             kill;
  logic             take;
  logic             in_bus;
  logic             err_hit;
  logic             beat_ok;
  logic             rx_pop;
  logic             tx_go;
  logic [REM_W-1:0] words;
  logic             unused_bits;

  // Abort and reset both abandon whatever is in flight
  assign kill = wb_rst_i | abort_i;

  assign words = REM_W'(block_size_i[BLKSIZE_W-1:2])
               * REM_W'(block_count_i);

  assign take = (state_q == S_IDLE)
              & (start_rx_i | start_tx_i)
              & ~kill;

  assign in_bus = (state_q == S_BUS) & ~kill;

`ifdef SD_DMA_ERR_EN
  assign err_hit = in_bus & m_wb_err_i;
`else
  assign err_hit = 1'b0;
`endif

  assign beat_ok = in_bus & m_wb_ack_i & ~err_hit;

  assign rx_pop = (state_q == S_WAIT) & rx_q
                & ~rx_fifo_empty_i & ~kill;

  assign tx_go = (state_q == S_WAIT) & ~rx_q
               & ~tx_fifo_full_i & ~kill;

  assign unused_bits = ^{block_size_i[1:0], dma_addr_i[1:0]};

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (take) begin
            state_d = (words == '0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (rx_pop | tx_go) begin
            state_d = S_BUS;
          end
        end
        S_BUS: begin
          if (err_hit) begin
            state_d = S_DONE;
          end else if (beat_ok) begin
            state_d = (rem_q == REM_W'(1)) ? S_DONE : S_WAIT;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output decode from state and qualified handshakes
  always_comb begin
    m_wb_cyc_o   = in_bus;
    m_wb_stb_o   = in_bus;
    m_wb_we_o    = in_bus & rx_q;
    m_wb_sel_o   = in_bus ? 4'hF : 4'h0;
    rx_fifo_rd_o = rx_pop;
    busy_o       = (state_q != S_IDLE);
    done_o       = (state_q == S_DONE) & ~kill;
  end

  // Transfer address, word counter, direction and data holding registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      addr_q <= '0;
      rem_q  <= '0;
      rx_q   <= 1'b0;
      wdat_q <= '0;
      tdat_q <= '0;
      twr_q  <= 1'b0;
    end else begin
      twr_q <= 1'b0;
      if (take) begin
        addr_q <= {dma_addr_i[ADDR_W-1:2], 2'b00};
        rem_q  <= words;
        rx_q   <= start_rx_i;
      end
      if (rx_pop) begin
        wdat_q <= rx_fifo_dat_i;
      end
      if (beat_ok) begin
        addr_q <= addr_q + ADDR_W'(4);
        rem_q  <= rem_q - REM_W'(1);
        if (!rx_q) begin
          tdat_q <= m_wb_dat_i;
          twr_q  <= 1'b1;
        end
      end
    end
  end

  assign m_wb_adr_o    = addr_q;
  assign m_wb_dat_o    = wdat_q;
  assign tx_fifo_dat_o = tdat_q;
  assign tx_fifo_wr_o  = twr_q;

`ifdef SD_DMA_ERR_EN
  logic err_q;

  // Sticky bus-error flag, cleared by reset or the next accepted start
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      err_q <= 1'b0;
    end else if (take) begin
      err_q <= 1'b0;
    end else if (err_hit) begin
      err_q <= 1'b1;
    end
  end

  assign dma_err_o = err_q;
`endif

endmodule

// File: tb/tb_sd_dma_master_wb.sv
// Scoreboard bench for sd_dma_master_wb.
// Define SD_DMA_ERR_EN to also exercise bus-error handling.
module tb_sd_dma_master_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_rx, start_tx, abort;
  logic [31:0] dma_addr;
  logic [11:0] blk_size;
  logic [15:0] blk_cnt;
  logic [31:0] adr, dat_o, dat_i;
  logic [3:0]  sel;
  logic        we, cyc, stb, ack, err;
  logic [31:0] rx_dat, tx_dat;
  logic        rx_empty, rx_rd, tx_full, tx_wr;
  logic        busy, done;
`ifdef SD_DMA_ERR_EN
  logic        dma_err;
`endif

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } bus_t;

  typedef struct {
    int cyc;
    bit err;
  } done_t;

  bus_t        exp_bus[$];
  logic [31:0] exp_tx[$];
  done_t       exp_done[$];
  logic [31:0] rxq[$];

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int rd_cnt = 0;
  int txw_cnt = 0;
  int beat_n = 0;
  int err_beat = 0;
  int dly = 0;
  bit ack_en = 1'b1;
  bit rand_dly = 1'b0;
  int base;

  bus_t  mb;
  done_t md;
  logic [31:0] mt;

  always #5 clk = ~clk;

  sd_dma_master_wb dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .start_rx_i      (start_rx),
    .start_tx_i      (start_tx),
    .abort_i         (abort),
    .dma_addr_i      (dma_addr),
    .block_size_i    (blk_size),
    .block_count_i   (blk_cnt),
    .m_wb_adr_o      (adr),
    .m_wb_dat_o      (dat_o),
    .m_wb_dat_i      (dat_i),
    .m_wb_sel_o      (sel),
    .m_wb_we_o       (we),
    .m_wb_cyc_o      (cyc),
    .m_wb_stb_o      (stb),
    .m_wb_ack_i      (ack),
`ifdef SD_DMA_ERR_EN
    .m_wb_err_i      (err),
    .dma_err_o       (dma_err),
`endif
    .rx_fifo_dat_i   (rx_dat),
    .rx_fifo_empty_i (rx_empty),
    .rx_fifo_rd_o    (rx_rd),
    .tx_fifo_dat_o   (tx_dat),
    .tx_fifo_full_i  (tx_full),
    .tx_fifo_wr_o    (tx_wr),
    .busy_o          (busy),
    .done_o          (done)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // memory slave: acks after dly cycles, optional error on one beat
  always @(posedge clk) begin
    #1;
    if (ack || err) begin
      ack = 1'b0;
      err = 1'b0;
    end else if (stb === 1'b1 && ack_en) begin
      if (dly > 0) begin
        dly = dly - 1;
      end else begin
        beat_n = beat_n + 1;
        if (err_beat != 0 && beat_n == err_beat) begin
          err = 1'b1;
        end else begin
          ack = 1'b1;
          if (!we) dat_i = mem(adr);
        end
        dly = rand_dly ? int'($urandom_range(0, 3)) : 0;
      end
    end
  end

  // rx FIFO model: show-ahead head, pop on rd
  always @(posedge clk) begin
    if (rx_rd === 1'b1) begin
      checks++;
      rd_cnt++;
      if (rxq.size() == 0) begin
        errors++;
        $display("FAIL rx_pop_empty got rd=1 want rd=0");
      end else begin
        void'(rxq.pop_front());
      end
    end
    #1;
    rx_empty = (rxq.size() == 0);
    rx_dat   = (rxq.size() != 0) ? rxq[0] : 32'h0;
  end

  // monitor: compares every DUT output event against the queues
  always @(negedge clk) begin
    if (!rst) begin
      if (stb === 1'b1 && ack === 1'b1) begin
        checks++;
        if (exp_bus.size() == 0) begin
          errors++;
          $display("FAIL bus_unexpected got adr=%h we=%b want none", adr, we);
        end else begin
          mb = exp_bus.pop_front();
          if (adr !== mb.adr || we !== mb.we || sel !== 4'hF ||
              (mb.we && dat_o !== mb.dat)) begin
            errors++;
            $display("FAIL bus_beat got adr=%h we=%b sel=%h dat=%h want adr=%h we=%b sel=f dat=%h",
                     adr, we, sel, dat_o, mb.adr, mb.we, mb.dat);
          end
        end
      end
      if (tx_wr === 1'b1) begin
        checks++;
        txw_cnt++;
        if (exp_tx.size() == 0) begin
          errors++;
          $display("FAIL tx_push_unexpected got dat=%h want none", tx_dat);
        end else begin
          mt = exp_tx.pop_front();
          if (tx_dat !== mt) begin
            errors++;
            $display("FAIL tx_push got dat=%h want %h", tx_dat, mt);
          end
        end
      end
      if (done === 1'b1) begin
        checks++;
        if (exp_done.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected got done=1 at cycle %0d want none", cyc_n);
        end else begin
          md = exp_done.pop_front();
          if (md.cyc >= 0 && md.cyc != cyc_n) begin
            errors++;
            $display("FAIL done_cycle got %0d want %0d", cyc_n, md.cyc);
          end
`ifdef SD_DMA_ERR_EN
          if (dma_err !== md.err) begin
            errors++;
            $display("FAIL done_err got %b want %b", dma_err, md.err);
          end
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic start(input bit rx, input bit tx, input logic [31:0] a,
                       input logic [11:0] bs, input logic [15:0] bc);
    start_rx = rx;
    start_tx = tx;
    dma_addr = a;
    blk_size = bs;
    blk_cnt  = bc;
    tick();
    start_rx = 1'b0;
    start_tx = 1'b0;
  endtask

  task automatic exp_w(input logic [31:0] a, input logic [31:0] d);
    bus_t e;
    e.adr = a;
    e.we  = 1'b1;
    e.dat = d;
    exp_bus.push_back(e);
  endtask

  task automatic exp_r(input logic [31:0] a);
    bus_t e;
    e.adr = a;
    e.we  = 1'b0;
    e.dat = 32'h0;
    exp_bus.push_back(e);
    exp_tx.push_back(mem(a));
  endtask

  task automatic exp_d(input int c, input bit e);
    done_t d;
    d.cyc = c;
    d.err = e;
    exp_done.push_back(d);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_bus.size() != 0 || exp_tx.size() != 0 ||
            exp_done.size() != 0 || busy !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL idle_timeout got bus=%0d tx=%0d done=%0d busy=%b want all 0",
               exp_bus.size(), exp_tx.size(), exp_done.size(), busy);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_rx = 1'b0; start_tx = 1'b0; abort = 1'b0;
    dma_addr = '0; blk_size = '0; blk_cnt = '0;
    dat_i = '0; ack = 1'b0; err = 1'b0;
    rx_dat = '0; rx_empty = 1'b1; tx_full = 1'b0;
    repeat (3) tick();
    chk("rst_bus", {cyc, stb, we, sel}, 32'h0);
    chk("rst_adr", adr, 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_misc", {rx_rd, tx_wr, busy, done}, 32'h0);
    chk("rst_txdat", tx_dat, 32'h0);
    rst = 1'b0;
    tick();

    // rx: 8-byte blocks x2, misaligned address
    for (int i = 0; i < 4; i++) rxq.push_back(32'hA0 + i);
    tick();
    exp_w(32'h1000_0000, 32'hA0);
    exp_w(32'h1000_0004, 32'hA1);
    exp_w(32'h1000_0008, 32'hA2);
    exp_w(32'h1000_000C, 32'hA3);
    exp_d(-1, 1'b0);
    base = rd_cnt;
    start(1'b1, 1'b0, 32'h1000_0002, 12'd8, 16'd2);
    chk("lat_wait_stb", {31'h0, stb}, 32'h0);
    chk("lat_wait_busy", {31'h0, busy}, 32'h1);
    tick();
    chk("lat_bus_stb", {31'h0, stb}, 32'h1);
    chk("lat_bus_sel", {28'h0, sel}, 32'hF);
    wait_idle(200);
    chk("rx_pops", rd_cnt - base, 4);

    // tx: 512 bytes with random ack delay
    rand_dly = 1'b1;
    for (int i = 0; i < 128; i++) exp_r(32'h2000_0000 + 32'(i * 4));
    exp_d(-1, 1'b0);
    base = txw_cnt;
    start(1'b0, 1'b1, 32'h2000_0000, 12'd512, 16'd1);
    wait_idle(3000);
    rand_dly = 1'b0;
    dly = 0;
    chk("tx_pushes", txw_cnt - base, 128);
    chk("tx_busy_after", {31'h0, busy}, 32'h0);

    // rx stall: FIFO runs dry after 2 of 4 words
    rxq.push_back(32'hB0);
    rxq.push_back(32'hB1);
    tick();
    exp_w(32'h3000_0000, 32'hB0);
    exp_w(32'h3000_0004, 32'hB1);
    exp_w(32'h3000_0008, 32'hB2);
    exp_w(32'h3000_000C, 32'hB3);
    exp_d(-1, 1'b0);
    start(1'b1, 1'b0, 32'h3000_0000, 12'd16, 16'd1);
    for (int n = 0; n < 100 && exp_bus.size() > 2; n++) tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("rx_stall_stb", {31'h0, stb}, 32'h0);
      tick();
    end
    rxq.push_back(32'hB2);
    rxq.push_back(32'hB3);
    wait_idle(200);

    // tx stall: FIFO full for 5 cycles
    tx_full = 1'b1;
    exp_r(32'h4000_0000);
    exp_r(32'h4000_0004);
    exp_d(-1, 1'b0);
    start(1'b0, 1'b1, 32'h4000_0000, 12'd8, 16'd1);
    for (int i = 0; i < 5; i++) begin
      chk("tx_stall_stb", {31'h0, stb}, 32'h0);
      tick();
    end
    tx_full = 1'b0;
    wait_idle(200);

    // zero length: done one cycle after start, no bus cycle
    start(1'b1, 1'b0, 32'h5000_0000, 12'd8, 16'd0);
    exp_d(cyc_n, 1'b0);
    chk("zero_cyc", {31'h0, cyc}, 32'h0);
    wait_idle(20);

    // wrap and ignored start while busy
    exp_r(32'hFFFF_FFFC);
    exp_r(32'h0000_0000);
    exp_d(-1, 1'b0);
    start(1'b0, 1'b1, 32'hFFFF_FFFC, 12'd4, 16'd2);
    tick();
    start(1'b1, 1'b0, 32'h5000_0000, 12'd8, 16'd9);
    wait_idle(200);

    // both starts: rx wins
    rxq.push_back(32'hC0);
    tick();
    exp_w(32'h6000_0000, 32'hC0);
    exp_d(-1, 1'b0);
    start(1'b1, 1'b1, 32'h6000_0000, 12'd4, 16'd1);
    wait_idle(200);

    // abort in BUS before ack
    ack_en = 1'b0;
    base = txw_cnt;
    start(1'b0, 1'b1, 32'h7000_0000, 12'd8, 16'd1);
    tick();
    chk("abort_pre_stb", {31'h0, stb}, 32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_cyc_stb", {30'h0, cyc, stb}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    repeat (4) tick();
    chk("abort_no_push", txw_cnt - base, 0);
    ack_en = 1'b1;
    rxq.push_back(32'hD0);
    tick();
    exp_w(32'h7100_0000, 32'hD0);
    exp_d(-1, 1'b0);
    start(1'b1, 1'b0, 32'h7100_0000, 12'd4, 16'd1);
    wait_idle(200);

`ifdef SD_DMA_ERR_EN
    // error on 2nd of 4 read beats
    beat_n = 0;
    err_beat = 2;
    base = txw_cnt;
    exp_r(32'h8000_0000);
    exp_d(-1, 1'b1);
    start(1'b0, 1'b1, 32'h8000_0000, 12'd16, 16'd1);
    wait_idle(200);
    err_beat = 0;
    chk("err_pushes", txw_cnt - base, 1);
    chk("err_sticky", {31'h0, dma_err}, 32'h1);
    rxq.push_back(32'hE0);
    tick();
    exp_w(32'h8100_0000, 32'hE0);
    exp_d(-1, 1'b0);
    start(1'b1, 1'b0, 32'h8100_0000, 12'd4, 16'd1);
    chk("err_clear", {31'h0, dma_err}, 32'h0);
    wait_idle(200);
`endif

    repeat (3) tick();
    chk("queues_empty",
        32'(exp_bus.size() + exp_tx.size() + exp_done.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
